// File: rtl/multi_queue_fifo_if.sv
// Push/pop/occupancy bundle for multi_queue_fifo.
// The flush pair exists only when MULTI_QUEUE_FIFO_FLUSH_EN is defined.
interface multi_queue_fifo_if #(
  parameter int WIDTH = 32,
  parameter int NQ    = 3,
  parameter int DEPTH = 4
);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic             push_valid;
  logic [QW-1:0]    push_qid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_req;
  logic [QW-1:0]    pop_qid;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_underflow;
  logic [NQ*CW-1:0] sizes;
`ifdef MULTI_QUEUE_FIFO_FLUSH_EN
  logic             flush_req;
  logic [QW-1:0]    flush_qid;

  modport master (
    output push_valid, push_qid, push_data, pop_req, pop_qid, flush_req, flush_qid,
    input  push_ready, pop_valid, pop_data, pop_underflow, sizes
  );
  modport slave (
    input  push_valid, push_qid, push_data, pop_req, pop_qid, flush_req, flush_qid,
    output push_ready, pop_valid, pop_data, pop_underflow, sizes
  );
`else
  modport master (
    output push_valid, push_qid, push_data, pop_req, pop_qid,
    input  push_ready, pop_valid, pop_data, pop_underflow, sizes
  );
  modport slave (
    input  push_valid, push_qid, push_data, pop_req, pop_qid,
    output push_ready, pop_valid, pop_data, pop_underflow, sizes
  );
`endif
endinterface

// File: rtl/multi_queue_fifo.sv
// NQ independent FIFOs of DEPTH words each in statically partitioned storage.
// Optional per-queue flush is built when MULTI_QUEUE_FIFO_FLUSH_EN is defined.
module multi_queue_fifo #(
  parameter int WIDTH = 32,
  parameter int NQ    = 3,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_l,
  multi_queue_fifo_if.slave   bus
);
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem  [NQ][DEPTH];
  logic [PW-1:0]    rptr [NQ];
  logic [PW-1:0]    wptr [NQ];
  logic [CW-1:0]    cnt  [NQ];

  logic [NQ-1:0]    push_hit;
  logic [NQ-1:0]    pop_hit;
  logic [NQ-1:0]    flush_hit;
  logic             sel_full;
  logic             sel_flush;
  logic             push_ready_w;
  logic [WIDTH-1:0] rd_data;
  logic [NQ*CW-1:0] sizes_w;

  logic             pop_valid_p1;
  logic             pop_underflow_p1;
  logic [WIDTH-1:0] pop_data_p1;

  // An out-of-range push_qid matches no queue and so reads as full.
  always_comb begin
    flush_hit = '0;
`ifdef MULTI_QUEUE_FIFO_FLUSH_EN
    for (int i = 0; i < NQ; i++)
      flush_hit[i] = bus.flush_req && (bus.flush_qid == QW'(i));
`endif
    sel_full  = 1'b1;
    sel_flush = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      if (bus.push_qid == QW'(i)) begin
        sel_full  = (cnt[i] == CW'(DEPTH));
        sel_flush = flush_hit[i];
      end
    end
    push_ready_w = !sel_full && !sel_flush;
  end

  always_comb begin
    push_hit = '0;
    pop_hit  = '0;
    rd_data  = '0;
    for (int i = 0; i < NQ; i++) begin
      push_hit[i] = bus.push_valid && push_ready_w && (bus.push_qid == QW'(i));
      pop_hit[i]  = bus.pop_req && (bus.pop_qid == QW'(i)) &&
                    (cnt[i] != '0) && !flush_hit[i];
      if (pop_hit[i])
        rd_data = mem[i][rptr[i]];
    end
  end

  // Stage p0 -> p1: pointer/count update and registered pop result
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      for (int i = 0; i < NQ; i++) begin
        rptr[i] <= '0;
        wptr[i] <= '0;
        cnt[i]  <= '0;
      end
      pop_valid_p1     <= 1'b0;
      pop_underflow_p1 <= 1'b0;
      pop_data_p1      <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        if (flush_hit[i]) begin
          rptr[i] <= '0;
          wptr[i] <= '0;
          cnt[i]  <= '0;
        end else begin
          if (push_hit[i]) wptr[i] <= wptr[i] + PW'(1);
          if (pop_hit[i])  rptr[i] <= rptr[i] + PW'(1);
          case ({push_hit[i], pop_hit[i]})
            2'b10:   cnt[i] <= cnt[i] + CW'(1);
            2'b01:   cnt[i] <= cnt[i] - CW'(1);
            default: cnt[i] <= cnt[i];
          endcase
        end
      end
      pop_valid_p1     <= |pop_hit;
      pop_underflow_p1 <= bus.pop_req && !(|pop_hit);
      if (|pop_hit)
        pop_data_p1 <= rd_data;
    end
  end

  // Storage is never cleared; writes are only suppressed while in reset.
  always_ff @(posedge clk) begin
    if (reset_l) begin
      for (int i = 0; i < NQ; i++)
        if (push_hit[i])
          mem[i][wptr[i]] <= bus.push_data;
    end
  end

  always_comb begin
    sizes_w = '0;
    for (int i = 0; i < NQ; i++)
      sizes_w[i*CW +: CW] = cnt[i];
  end

  assign bus.push_ready    = push_ready_w;
  assign bus.pop_valid     = pop_valid_p1;
  assign bus.pop_data      = pop_data_p1;
  assign bus.pop_underflow = pop_underflow_p1;
  assign bus.sizes         = sizes_w;
endmodule
